// File: rtl/ysyx_25020047_pkg.sv
// rtl/ysyx_25020047_pkg.sv - shared response codes and FSM state types for the SRAM responder
package ysyx_25020047_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      R_IDLE,
      R_WAIT,
      R_RESP
   } r_state_e;

   typedef enum logic [1:0] {
      W_IDLE,
      W_WAIT,
      W_RESP
   } w_state_e;

endpackage

// File: rtl/ysyx_25020047_lfsr.sv
// rtl/ysyx_25020047_lfsr.sv - 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, free-running
//
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset, loads SEED
//   lfsr  - current register value, advances every cycle
module ysyx_25020047_lfsr #(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [7:0] lfsr
);

   logic feedback;

   // Taps at stages 8,6,5,4 of a left-shifting register.
   assign feedback = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr <= SEED;
      end else begin
         lfsr <= {lfsr[6:0], feedback};
      end
   end

endmodule

// File: rtl/ysyx_25020047_sram.sv
// rtl/ysyx_25020047_sram.sv - AXI4-Lite SRAM responder with configurable response latency
//
// Ports:
//   clk, rst_n                          - clock (rising edge), asynchronous active-low reset
//   araddr, arvalid, arready            - read-address channel
//   rdata, rresp, rvalid, rready        - read-data channel
//   awaddr, awvalid, awready            - write-address channel
//   wdata, wstrb, wvalid, wready        - write-data channel
//   bresp, bvalid, bready               - write-response channel
// Parameters: ADDR_W (2^ADDR_W 32-bit words), LAT (base latency, >= 1).
// Macro YSYX_25020047_SRAM_RANDLAT_EN: latency becomes LAT + lfsr[2:0] per transaction.
module ysyx_25020047_sram
   import ysyx_25020047_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int LAT    = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] araddr,
   input  logic        arvalid,
   output logic        arready,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rvalid,
   input  logic        rready,
   input  logic [31:0] awaddr,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wvalid,
   output logic        wready,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);

   localparam int CNT_W = 8;

   r_state_e r_state, r_next;
   w_state_e w_state, w_next;

   logic [CNT_W-1:0] lat_load;
   logic [CNT_W-1:0] r_cnt, w_cnt;
   logic [29:0]      r_word_q, w_word_q;
   logic [31:0]      w_data_q;
   logic [3:0]       w_strb_q;
   logic             aw_held, w_held;

   logic [31:0] mem [2**ADDR_W];

   logic ar_fire, aw_fire, w_fire;
   logic r_done, w_done, w_start;
   logic r_in_range, w_in_range;
   logic [ADDR_W-1:0] r_idx, w_idx;

   // Byte-lane offset bits are the initiator's concern and are not decoded.
   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^{araddr[1:0], awaddr[1:0]};

`ifdef YSYX_25020047_SRAM_RANDLAT_EN
   logic [7:0] lfsr_q;
   logic       unused_lfsr_bits;

   ysyx_25020047_lfsr #(.SEED(8'hA5)) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .lfsr  (lfsr_q)
   );

   // Counter holds remaining WAIT cycles minus one, so LAT-1 gives LAT cycles.
   assign lat_load         = CNT_W'(LAT - 1) + CNT_W'(lfsr_q[2:0]);
   assign unused_lfsr_bits = ^lfsr_q[7:3];
`else
   assign lat_load = CNT_W'(LAT - 1);
`endif

   assign ar_fire = arvalid && arready;
   assign aw_fire = awvalid && awready;
   assign w_fire  = wvalid && wready;

   assign r_done  = (r_state == R_WAIT) && (r_cnt == '0);
   assign w_done  = (w_state == W_WAIT) && (w_cnt == '0);
   assign w_start = (w_state == W_IDLE) && (w_next == W_WAIT);

   assign r_in_range = (r_word_q[29:ADDR_W] == '0);
   assign w_in_range = (w_word_q[29:ADDR_W] == '0);
   assign r_idx      = r_word_q[ADDR_W-1:0];
   assign w_idx      = w_word_q[ADDR_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= R_IDLE;
         w_state <= W_IDLE;
      end else begin
         r_state <= r_next;
         w_state <= w_next;
      end
   end

   always_comb begin
      r_next  = r_state;
      arready = 1'b0;
      rvalid  = 1'b0;
      case (r_state)
         R_IDLE: begin
            arready = 1'b1;
            if (arvalid) r_next = R_WAIT;
         end
         R_WAIT: begin
            if (r_cnt == '0) r_next = R_RESP;
         end
         R_RESP: begin
            rvalid = 1'b1;
            if (rready) r_next = R_IDLE;
         end
         default: r_next = R_IDLE;
      endcase
   end

   always_comb begin
      w_next  = w_state;
      awready = 1'b0;
      wready  = 1'b0;
      bvalid  = 1'b0;
      case (w_state)
         W_IDLE: begin
            awready = !aw_held;
            wready  = !w_held;
            // Either channel is complete once held or transferring this cycle.
            if ((aw_held || awvalid) && (w_held || wvalid)) w_next = W_WAIT;
         end
         W_WAIT: begin
            if (w_cnt == '0) w_next = W_RESP;
         end
         W_RESP: begin
            bvalid = 1'b1;
            if (bready) w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         w_cnt    <= '0;
         rdata    <= '0;
         rresp    <= RESP_OKAY;
         bresp    <= RESP_OKAY;
         aw_held  <= 1'b0;
         w_held   <= 1'b0;
         r_word_q <= '0;
         w_word_q <= '0;
         w_data_q <= '0;
         w_strb_q <= '0;
      end else begin
         if (ar_fire) begin
            r_word_q <= araddr[31:2];
            r_cnt    <= lat_load;
         end else if ((r_state == R_WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end

         // Reads the array before this edge's write lands, so a colliding
         // write commit is not visible to this read.
         if (r_done) begin
            rdata <= r_in_range ? mem[r_idx] : '0;
            rresp <= r_in_range ? RESP_OKAY : RESP_DECERR;
         end

         if (aw_fire) begin
            w_word_q <= awaddr[31:2];
            aw_held  <= 1'b1;
         end
         if (w_fire) begin
            w_data_q <= wdata;
            w_strb_q <= wstrb;
            w_held   <= 1'b1;
         end

         // Clearing here overrides a same-cycle set above.
         if (w_start) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            w_cnt   <= lat_load;
         end else if ((w_state == W_WAIT) && (w_cnt != '0)) begin
            w_cnt <= w_cnt - CNT_W'(1);
         end

         if (w_done) begin
            bresp <= w_in_range ? RESP_OKAY : RESP_DECERR;
         end
      end
   end

   // Contents survive reset; w_done is gated by the reset state, so an
   // interrupted write never reaches the array.
   always_ff @(posedge clk) begin
      if (w_done && w_in_range) begin
         for (int i = 0; i < 4; i++) begin
            if (w_strb_q[i]) mem[w_idx][8*i +: 8] <= w_data_q[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_ysyx_25020047_sram.sv
// tb/tb_ysyx_25020047_sram.sv - scoreboard bench for the SRAM responder
module tb_ysyx_25020047_sram;

   localparam int ADDR_W = 12;
   localparam int LAT    = 1;
   localparam logic [1:0] OK  = 2'b00;
   localparam logic [1:0] DEC = 2'b11;

   logic        clk;
   logic        rst_n;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   int checks = 0;
   int errors = 0;

   logic [33:0] r_q[$];
   logic [1:0]  b_q[$];

   ysyx_25020047_sram #(.ADDR_W(ADDR_W), .LAT(LAT)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .araddr  (araddr),
      .arvalid (arvalid),
      .arready (arready),
      .rdata   (rdata),
      .rresp   (rresp),
      .rvalid  (rvalid),
      .rready  (rready),
      .awaddr  (awaddr),
      .awvalid (awvalid),
      .awready (awready),
      .wdata   (wdata),
      .wstrb   (wstrb),
      .wvalid  (wvalid),
      .wready  (wready),
      .bresp   (bresp),
      .bvalid  (bvalid),
      .bready  (bready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic monitor();
      logic [33:0] er;
      logic [1:0]  eb;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (rvalid && rready) begin
               if (r_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL r_unexpected: response %h with nothing pending", {rdata, rresp});
               end else begin
                  er = r_q.pop_front();
                  chk("r_data_resp", {30'd0, rdata, rresp}, {30'd0, er});
               end
            end
            if (bvalid && bready) begin
               if (b_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL b_unexpected: bresp %h with nothing pending", bresp);
               end else begin
                  eb = b_q.pop_front();
                  chk("b_resp", {62'd0, bresp}, {62'd0, eb});
               end
            end
         end
      end
   endtask

   task automatic do_aw(input logic [31:0] a);
      bit ok = 1'b0;
      awaddr  = a;
      awvalid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (awready) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      awvalid = 1'b0;
      if (!ok) begin
         checks++; errors++;
         $display("FAIL aw_timeout: awready low 20 cycles, addr %h", a);
      end
   endtask

   task automatic do_w(input logic [31:0] d, input logic [3:0] s);
      bit ok = 1'b0;
      wdata  = d;
      wstrb  = s;
      wvalid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (wready) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      wvalid = 1'b0;
      if (!ok) begin
         checks++; errors++;
         $display("FAIL w_timeout: wready low 20 cycles, data %h", d);
      end
   endtask

   task automatic wait_b();
      bit ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bvalid) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      if (!ok) begin
         checks++; errors++;
         $display("FAIL b_timeout: bvalid low 40 cycles");
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic [1:0] resp);
      b_q.push_back(resp);
      fork
         do_aw(a);
         do_w(d, s);
      join
      wait_b();
   endtask

   // hold > 0: rready is expected low on entry and is raised after hold cycles.
   task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp,
                     input int hold);
      bit ok = 1'b0;
      int n;
      r_q.push_back({d, resp});
      araddr  = a;
      arvalid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (arready) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      arvalid = 1'b0;
      if (!ok) begin
         checks++; errors++;
         $display("FAIL ar_timeout: arready low 20 cycles, addr %h", a);
      end
      n  = 1;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (rvalid) begin ok = 1'b1; break; end
         n++;
      end
      chk("r_latency", {63'd0, ok}, 64'd1);
      chk("r_latency_cycles", 64'(n), 64'(LAT + 1));
      for (int k = 0; k < hold; k++) begin
         chk("r_stall_hold", {29'd0, rvalid, arready, rdata}, {29'd0, 1'b1, 1'b0, d});
         @(negedge clk);
      end
      if (hold > 0) begin
         @(posedge clk); #1;
         rready = 1'b1;
         @(negedge clk);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n   = 1'b0;
      araddr  = '0;
      arvalid = 1'b0;
      rready  = 1'b1;
      awaddr  = '0;
      awvalid = 1'b0;
      wdata   = '0;
      wstrb   = '0;
      wvalid  = 1'b0;
      bready  = 1'b1;
      fork
         monitor();
      join_none

      #1;
      chk("reset_handshake", {59'd0, arready, awready, wready, rvalid, bvalid}, 64'b11100);
      chk("reset_resp", {28'd0, rdata, rresp, bresp}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_reset_ready", {61'd0, arready, awready, wready}, 64'b111);
      @(posedge clk); #1;

      // full word write then read, with latency measurement
      wr(32'h10, 32'hDEADBEEF, 4'hF, OK);
      rd(32'h10, 32'hDEADBEEF, OK, 0);

      // single byte lane merge
      wr(32'h20, 32'h11223344, 4'hF, OK);
      wr(32'h20, 32'h00AB0000, 4'b0100, OK);
      rd(32'h20, 32'h11AB3344, OK, 0);

      // empty strobe writes nothing; low address bits ignored
      wr(32'h10, 32'h00000000, 4'h0, OK);
      rd(32'h13, 32'hDEADBEEF, OK, 0);

      // w three cycles ahead of aw
      b_q.push_back(OK);
      do_w(32'h5A5A5A5A, 4'hF);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("w_first_no_b", {62'd0, bvalid, wready}, 64'd0);
         @(posedge clk); #1;
      end
      do_aw(32'h24);
      chk("w_first_no_b_after_aw", {63'd0, bvalid}, 64'd0);
      wait_b();
      rd(32'h24, 32'h5A5A5A5A, OK, 0);

      // rready held low for 5 cycles
      rready = 1'b0;
      rd(32'h20, 32'h11AB3344, OK, 5);

      // read capture and write commit on the same edge to the same word
      wr(32'h30, 32'h01020304, 4'hF, OK);
      fork
         rd(32'h30, 32'h01020304, OK, 0);
         wr(32'h30, 32'hA0B0C0D0, 4'hF, OK);
      join
      rd(32'h30, 32'hA0B0C0D0, OK, 0);

      // out of range: no write, DECERR, zero data
      wr(32'h0, 32'h55AA55AA, 4'hF, OK);
      wr(32'h1 << (ADDR_W + 2), 32'hFFFFFFFF, 4'hF, DEC);
      rd(32'h1 << (ADDR_W + 2), 32'h0, DEC, 0);
      rd(32'h80000000, 32'h0, DEC, 0);
      rd(32'h0, 32'h55AA55AA, OK, 0);

      // reset while the write sits in W_WAIT
      wr(32'h40, 32'hCAFEF00D, 4'hF, OK);
      fork
         do_aw(32'h40);
         do_w(32'h12345678, 4'hF);
      join
      rst_n = 1'b0;
      #1;
      chk("rst_mid_bvalid", {63'd0, bvalid}, 64'd0);
      chk("rst_mid_ready", {61'd0, arready, awready, wready}, 64'b111);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_mid_ready_after", {61'd0, arready, awready, wready}, 64'b111);
      @(posedge clk); #1;
      rd(32'h40, 32'hCAFEF00D, OK, 0);

      @(negedge clk);
      chk("queues_drained", 64'(r_q.size() + b_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
